// File: rtl/midi_note_decoder_if.sv
// MIDI line and decoded note state between the line source and midi_note_decoder.
// The master drives MIDI_RX and observes the decoded state; the slave is the decoder.
interface midi_note_decoder_if;
    logic        MIDI_RX;
    logic        isNoteOn;
    logic [23:0] noteSampleTicks;
    logic [7:0]  modulationValue;
    logic        frameError;

    modport master (
        output MIDI_RX,
        input  isNoteOn, noteSampleTicks, modulationValue, frameError
    );

    modport slave (
        input  MIDI_RX,
        output isNoteOn, noteSampleTicks, modulationValue, frameError
    );
endinterface

// File: rtl/midi_note_decoder.sv
// MIDI UART + running-status parser + note-to-period lookup for a monophonic synth voice.
// Outputs update 1 cycle after the byte completing a message; no backpressure, line is free-running.
module midi_note_decoder #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    midi_note_decoder_if.slave  io_midi
);

    localparam int BIT_TICKS = CLK_HZ / BAUD;
    localparam int CW        = $clog2(BIT_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_TICKS / 2 - 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} uart_state_t;

    uart_state_t   r_state;
    uart_state_t   w_state_nxt;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_byte_vld;
    logic          w_cnt_clr;
    logic          w_shift_en;
    logic          w_stop_ok;
    logic          w_frame_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_ok   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            ARM: begin
                // Needs a full bit time of continuous idle before trusting the line.
                if (!r_rx_sync) begin
                    w_cnt_clr = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == HALF) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_sync) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = ARM;
                    end
                end
            end
            default: w_state_nxt = ARM;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_state    <= ARM;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
        end else begin
            r_rx_meta  <= io_midi.MIDI_RX;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_byte_vld <= w_stop_ok;
            if (w_shift_en) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    logic [7:0] r_status;
    logic       r_run_vld;
    logic       r_idx;
    logic [6:0] r_data0;
    logic       r_note_on;
    logic       r_note_vld;
    logic [6:0] r_note;
    logic [7:0] r_mod;
    logic       w_realtime;
    logic       w_need2;
    logic       w_chan_ok;
    logic [6:0] w_d1;
    logic [6:0] w_d2;

    assign w_realtime = (r_shift[7:3] == 5'b11111);
    assign w_need2    = !((r_status[7:4] == 4'hC) || (r_status[7:4] == 4'hD));
    assign w_chan_ok  = (OMNI != 0) || (r_status[3:0] == 4'(CHANNEL));
    assign w_d1       = w_need2 ? r_data0 : r_shift[6:0];
    assign w_d2       = r_shift[6:0];

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_status   <= '0;
            r_run_vld  <= 1'b0;
            r_idx      <= 1'b0;
            r_data0    <= '0;
            r_note_on  <= 1'b0;
            r_note_vld <= 1'b0;
            r_note     <= '0;
            r_mod      <= '0;
        end else if (r_byte_vld && !w_realtime) begin
            if (r_shift[7:4] == 4'hF) begin
                r_run_vld <= 1'b0;
                r_idx     <= 1'b0;
            end else if (r_shift[7]) begin
                r_status  <= r_shift;
                r_run_vld <= 1'b1;
                r_idx     <= 1'b0;
            end else if (r_run_vld) begin
                if (w_need2 && !r_idx) begin
                    r_data0 <= r_shift[6:0];
                    r_idx   <= 1'b1;
                end else begin
                    // Message complete; a foreign channel still consumes its data bytes.
                    r_idx <= 1'b0;
                    if (w_chan_ok) begin
                        case (r_status[7:4])
                            4'h9: begin
                                if (w_d2 != 7'd0) begin
                                    r_note_on  <= 1'b1;
                                    r_note_vld <= 1'b1;
                                    r_note     <= w_d1;
                                end else if (r_note_on && (w_d1 == r_note)) begin
                                    r_note_on <= 1'b0;
                                end
                            end
                            4'h8: begin
                                if (r_note_on && (w_d1 == r_note)) begin
                                    r_note_on <= 1'b0;
                                end
                            end
                            4'hB: begin
                                if (w_d1 == 7'd1) begin
                                    r_mod <= {w_d2, w_d2[6]};
                                end else if (w_d1 == 7'd123) begin
                                    r_note_on <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    logic [6:0]  w_rem;
    logic [3:0]  w_oct;
    logic [22:0] w_base;

    // Octave/semitone split by repeated subtraction of 12; at most 10 steps for notes up to 127.
    always_comb begin
        w_rem = r_note;
        w_oct = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_rem >= 7'd12) begin
                w_rem = w_rem - 7'd12;
                w_oct = w_oct + 4'd1;
            end
        end
        case (w_rem)
            7'd0:    w_base = 23'd6115610;
            7'd1:    w_base = 23'd5772367;
            7'd2:    w_base = 23'd5448389;
            7'd3:    w_base = 23'd5142595;
            7'd4:    w_base = 23'd4853963;
            7'd5:    w_base = 23'd4581531;
            7'd6:    w_base = 23'd4324390;
            7'd7:    w_base = 23'd4081680;
            7'd8:    w_base = 23'd3852593;
            7'd9:    w_base = 23'd3636364;
            7'd10:   w_base = 23'd3432270;
            7'd11:   w_base = 23'd3239632;
            default: w_base = 23'd0;
        endcase
    end

    assign io_midi.isNoteOn        = r_note_on;
    assign io_midi.noteSampleTicks = r_note_vld ? ({1'b0, w_base} >> w_oct) : 24'd0;
    assign io_midi.modulationValue = r_mod;
    assign io_midi.frameError      = w_frame_err;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: channel-0 and omni instances share one MIDI line,
// each compared against a message-level reference model.
module tb_midi_note_decoder;

    localparam int CLK_HZ = 500_000;
    localparam int BAUD   = 31250;
    localparam int BT     = CLK_HZ / BAUD;
    localparam int BASE [12] = '{6115610, 5772367, 5448389, 5142595, 4853963, 4581531,
                                 4324390, 4081680, 3852593, 3636364, 3432270, 3239632};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    midi_note_decoder_if if0();
    midi_note_decoder_if if1();
    assign if0.MIDI_RX = rx_line;
    assign if1.MIDI_RX = rx_line;

    midi_note_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0), .OMNI(0)) u_dut (
        .CLOCK_50(clk), .RESET(rst), .io_midi(if0));
    midi_note_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0), .OMNI(1)) u_omni (
        .CLOCK_50(clk), .RESET(rst), .io_midi(if1));

    logic        obs_on    [2];
    logic [23:0] obs_ticks [2];
    logic [7:0]  obs_mod   [2];
    logic        obs_fe    [2];
    assign obs_on[0] = if0.isNoteOn;         assign obs_on[1] = if1.isNoteOn;
    assign obs_ticks[0] = if0.noteSampleTicks; assign obs_ticks[1] = if1.noteSampleTicks;
    assign obs_mod[0] = if0.modulationValue;  assign obs_mod[1] = if1.modulationValue;
    assign obs_fe[0] = if0.frameError;        assign obs_fe[1] = if1.frameError;

    int   fe_cycles [2] = '{0, 0};
    int   fe_rises  [2] = '{0, 0};
    logic fe_prev   [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (obs_fe[d]) fe_cycles[d]++;
            if (obs_fe[d] && !fe_prev[d]) fe_rises[d]++;
            fe_prev[d] = obs_fe[d];
        end
    end

    // Message-level model: status byte plus the list of data bytes collected so far.
    int m_on [2], m_note [2], m_ticks [2], m_mod [2], m_run [2], m_pend0 [2], m_npend [2];

    function automatic int period(input int n);
        return BASE[n % 12] >> (n / 12);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_on[d] = 0; m_note[d] = 0; m_ticks[d] = 0; m_mod[d] = 0;
            m_run[d] = 0; m_pend0[d] = 0; m_npend[d] = 0;
        end
    endtask

    task automatic model_byte(input int d, input int b);
        int hi, need, a, v;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_run[d] = 0; m_npend[d] = 0; return; end
        if (b >= 'h80) begin m_run[d] = b; m_npend[d] = 0; return; end
        if (m_run[d] == 0) return;
        hi = m_run[d] / 16;
        need = (hi == 12 || hi == 13) ? 1 : 2;
        if (need == 2 && m_npend[d] == 0) begin m_pend0[d] = b; m_npend[d] = 1; return; end
        a = (need == 2) ? m_pend0[d] : b;
        v = b;
        m_npend[d] = 0;
        if (d == 0 && (m_run[d] % 16) != 0) return;
        case (hi)
            9:  if (v != 0) begin m_on[d] = 1; m_note[d] = a; m_ticks[d] = period(a); end
                else if (m_on[d] != 0 && a == m_note[d]) m_on[d] = 0;
            8:  if (m_on[d] != 0 && a == m_note[d]) m_on[d] = 0;
            11: if (a == 1) m_mod[d] = ((v * 2) & 255) | (v / 64);
                else if (a == 123) m_on[d] = 0;
            default: ;
        endcase
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int b, input bit good_stop);
        logic [7:0] bb;
        bb = b[7:0];
        if (good_stop) begin
            model_byte(0, b);
            model_byte(1, b);
        end
        rx_line = 1'b0;
        wait_cyc(BT);
        for (int i = 0; i < 8; i++) begin
            rx_line = bb[i];
            wait_cyc(BT);
        end
        rx_line = good_stop;
        wait_cyc(BT);
        rx_line = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send3(input int a, input int b, input int c);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_line = 1'b1;
        wait_cyc(5);
        for (int d = 0; d < 2; d++) begin
            total++; if (obs_on[d] !== 1'b0) begin bad++; $display("FAIL reset_on[%0d] got %0b want 0", d, obs_on[d]); end
            total++; if (obs_ticks[d] !== 24'd0) begin bad++; $display("FAIL reset_ticks[%0d] got %0d want 0", d, obs_ticks[d]); end
            total++; if (obs_mod[d] !== 8'd0) begin bad++; $display("FAIL reset_mod[%0d] got %0d want 0", d, obs_mod[d]); end
            total++; if (obs_fe[d] !== 1'b0) begin bad++; $display("FAIL reset_fe[%0d] got %0b want 0", d, obs_fe[d]); end
        end
        rst = 1'b0;
        model_reset();
        wait_cyc(3 * BT);
    endtask

    task automatic test_first_note();
        bit   seen;
        logic pre, post;
        seen = 1'b0; pre = 1'bx; post = 1'bx;
        send_byte('h90, 1'b1);
        send_byte('h3C, 1'b1);
        fork
            send_byte('h64, 1'b1);
            begin
                for (int c = 0; c < 12 * BT; c++) begin
                    @(negedge clk);
                    if (u_dut.r_byte_vld === 1'b1) begin
                        pre = if0.isNoteOn;
                        @(negedge clk);
                        post = if0.isNoteOn;
                        seen = 1'b1;
                        break;
                    end
                end
            end
        join
        total++; if (!seen) begin bad++; $display("FAIL first_note_bytevalid_timeout got none want pulse"); end
        total++; if ({pre, post} !== 2'b01) begin bad++; $display("FAIL first_note_latency got %b want 01", {pre, post}); end
        total++; if (obs_ticks[0] !== 24'd191112) begin bad++; $display("FAIL first_note_ticks got %0d want 191112", obs_ticks[0]); end
        for (int d = 0; d < 2; d++) begin
            total++; if (obs_on[d] !== 1'(m_on[d])) begin bad++; $display("FAIL first_note_on[%0d] got %0b want %0d", d, obs_on[d], m_on[d]); end
            total++; if (obs_ticks[d] !== 24'(m_ticks[d])) begin bad++; $display("FAIL first_note_model_ticks[%0d] got %0d want %0d", d, obs_ticks[d], m_ticks[d]); end
        end
    endtask

    task automatic test_running_status();
        send3('h90, 'h45, 'h64);
        total++; if ({obs_on[0], obs_ticks[0]} !== {1'b1, 24'd113636}) begin bad++; $display("FAIL rs_on got on=%0b ticks=%0d want on=1 ticks=113636", obs_on[0], obs_ticks[0]); end
        send_byte('h45, 1'b1);
        send_byte('h00, 1'b1);
        total++; if ({obs_on[0], obs_ticks[0]} !== {1'b0, 24'd113636}) begin bad++; $display("FAIL rs_off got on=%0b ticks=%0d want on=0 ticks=113636", obs_on[0], obs_ticks[0]); end
        for (int d = 0; d < 2; d++) begin
            total++; if (obs_on[d] !== 1'(m_on[d])) begin bad++; $display("FAIL rs_model_on[%0d] got %0b want %0d", d, obs_on[d], m_on[d]); end
        end
    endtask

    task automatic test_last_note();
        send3('h90, 'h3C, 'h64);
        send3('h90, 'h45, 'h64);
        send3('h80, 'h3C, 'h40);
        total++; if ({obs_on[0], obs_ticks[0]} !== {1'b1, 24'd113636}) begin bad++; $display("FAIL last_note_stale_off got on=%0b ticks=%0d want on=1 ticks=113636", obs_on[0], obs_ticks[0]); end
        send3('h80, 'h45, 'h40);
        total++; if (obs_on[0] !== 1'b0) begin bad++; $display("FAIL last_note_off got %0b want 0", obs_on[0]); end
    endtask

    task automatic test_modulation();
        send3('hB0, 'h01, 'h7F);
        total++; if (obs_mod[0] !== 8'd255) begin bad++; $display("FAIL mod_7f got %0d want 255", obs_mod[0]); end
        send3('hB0, 'h01, 'h40);
        total++; if (obs_mod[0] !== 8'd129) begin bad++; $display("FAIL mod_40 got %0d want 129", obs_mod[0]); end
        send3('hB0, 'h07, 'h7F);
        total++; if (obs_mod[0] !== 8'd129) begin bad++; $display("FAIL mod_other_cc got %0d want 129", obs_mod[0]); end
        send3('h90, 'h3C, 'h64);
        send3('hB0, 'h7B, 'h00);
        total++; if (obs_on[0] !== 1'b0) begin bad++; $display("FAIL all_notes_off got %0b want 0", obs_on[0]); end
        for (int d = 0; d < 2; d++) begin
            total++; if (obs_mod[d] !== 8'(m_mod[d])) begin bad++; $display("FAIL mod_model[%0d] got %0d want %0d", d, obs_mod[d], m_mod[d]); end
        end
    endtask

    task automatic test_realtime();
        send_byte('h90, 1'b1);
        send_byte('hF8, 1'b1);
        send_byte('h3C, 1'b1);
        send_byte('hF8, 1'b1);
        send_byte('h64, 1'b1);
        total++; if ({obs_on[0], obs_ticks[0]} !== {1'b1, 24'd191112}) begin bad++; $display("FAIL realtime got on=%0b ticks=%0d want on=1 ticks=191112", obs_on[0], obs_ticks[0]); end
    endtask

    task automatic test_channel();
        send3('hB0, 'h7B, 'h00);
        send3('h91, 'h3C, 'h64);
        total++; if (obs_on[0] !== 1'b0) begin bad++; $display("FAIL chan_mismatch_on got %0b want 0", obs_on[0]); end
        total++; if ({obs_on[1], obs_ticks[1]} !== {1'b1, 24'd191112}) begin bad++; $display("FAIL omni_on got on=%0b ticks=%0d want on=1 ticks=191112", obs_on[1], obs_ticks[1]); end
        for (int d = 0; d < 2; d++) begin
            total++; if (obs_on[d] !== 1'(m_on[d])) begin bad++; $display("FAIL chan_model_on[%0d] got %0b want %0d", d, obs_on[d], m_on[d]); end
        end
    endtask

    task automatic test_frame_error();
        int c0 [2], r0 [2];
        send3('hB0, 'h7B, 'h00);
        for (int d = 0; d < 2; d++) begin c0[d] = fe_cycles[d]; r0[d] = fe_rises[d]; end
        send_byte('h90, 1'b1);
        send_byte('h3C, 1'b0);
        wait_cyc(3 * BT);
        for (int d = 0; d < 2; d++) begin
            total++; if (fe_cycles[d] - c0[d] != 1) begin bad++; $display("FAIL fe_width[%0d] got %0d want 1", d, fe_cycles[d] - c0[d]); end
            total++; if (fe_rises[d] - r0[d] != 1) begin bad++; $display("FAIL fe_pulses[%0d] got %0d want 1", d, fe_rises[d] - r0[d]); end
            total++; if (obs_on[d] !== 1'b0) begin bad++; $display("FAIL fe_dropped_on[%0d] got %0b want 0", d, obs_on[d]); end
        end
        send3('h90, 'h3C, 'h64);
        for (int d = 0; d < 2; d++) begin
            total++; if ({obs_on[d], obs_ticks[d]} !== {1'b1, 24'd191112}) begin bad++; $display("FAIL fe_recover[%0d] got on=%0b ticks=%0d want on=1 ticks=191112", d, obs_on[d], obs_ticks[d]); end
        end
    endtask

    task automatic test_reset_mid_byte();
        send3('hB0, 'h01, 'h55);
        rx_line = 1'b0;
        wait_cyc(BT);
        rx_line = 1'b1;
        wait_cyc(2 * BT);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        model_reset();
        wait_cyc(1);
        for (int d = 0; d < 2; d++) begin
            total++; if ({obs_on[d], obs_ticks[d], obs_mod[d]} !== 33'd0) begin bad++; $display("FAIL midreset[%0d] got on=%0b ticks=%0d mod=%0d want all 0", d, obs_on[d], obs_ticks[d], obs_mod[d]); end
        end
        wait_cyc(3 * BT);
        send3('h90, 'h45, 'h64);
        total++; if ({obs_on[0], obs_ticks[0]} !== {1'b1, 24'd113636}) begin bad++; $display("FAIL midreset_rearm got on=%0b ticks=%0d want on=1 ticks=113636", obs_on[0], obs_ticks[0]); end
    endtask

    task automatic test_random();
        int kind, ch, n, v, st, last_st, prev_n, fe0;
        last_st = -1;
        prev_n = 60;
        fe0 = fe_cycles[0] + fe_cycles[1];
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 7);
            ch = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: n = 0;
                1: n = 127;
                2: n = prev_n;
                default: n = $urandom_range(0, 127);
            endcase
            v = $urandom_range(0, 127);
            case (kind)
                0: begin st = 'h90; v = $urandom_range(1, 127); prev_n = n; end
                1: begin st = 'h90; v = 0; end
                2: st = 'h80;
                3: begin st = 'hB0; n = 1; end
                4: begin st = 'hB0; n = 123; end
                5: begin st = 'hB0; n = $urandom_range(2, 120); end
                6: st = 'hC0;
                default: st = 'hF0;
            endcase
            if (st == 'hF0) begin
                send_byte('hF0, 1'b1);
                send_byte(v, 1'b1);
                send_byte('hF7, 1'b1);
                last_st = -1;
            end else begin
                st = st + ch;
                if (st != last_st || $urandom_range(0, 1) == 0) send_byte(st, 1'b1);
                last_st = st;
                if ($urandom_range(0, 3) == 0) send_byte('hF8, 1'b1);
                send_byte(n, 1'b1);
                if (st < 'hC0) send_byte(v, 1'b1);
            end
            for (int d = 0; d < 2; d++) begin
                total++; if (obs_on[d] !== 1'(m_on[d])) begin bad++; $display("FAIL rand_on[%0d] it=%0d got %0b want %0d", d, it, obs_on[d], m_on[d]); end
                total++; if (obs_ticks[d] !== 24'(m_ticks[d])) begin bad++; $display("FAIL rand_ticks[%0d] it=%0d got %0d want %0d", d, it, obs_ticks[d], m_ticks[d]); end
                total++; if (obs_mod[d] !== 8'(m_mod[d])) begin bad++; $display("FAIL rand_mod[%0d] it=%0d got %0d want %0d", d, it, obs_mod[d], m_mod[d]); end
            end
        end
        total++; if (fe_cycles[0] + fe_cycles[1] != fe0) begin bad++; $display("FAIL rand_spurious_fe got %0d want %0d", fe_cycles[0] + fe_cycles[1], fe0); end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_running_status();
        test_last_note();
        test_modulation();
        test_realtime();
        test_channel();
        test_frame_error();
        test_reset_mid_byte();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
